// File: rtl/arilla_ram_responder.sv
// arilla_ram_responder
//   Word-organised on-chip RAM acting as a responder on the arilla bus.
//   The block decodes its own address window and answers held read/write
//   requests. Each transfer is stretched by WaitStates cycles through the
//   inhibit line. Read data goes onto a wired-OR return, so data_out is
//   zero whenever this block is not presenting a read completion.
//
// Ports
//   clk          clock
//   rst_n        asynchronous active-low reset (RAM contents are kept)
//   address      byte address from the initiator (bits [1:0] ignored)
//   byte_enable  write lane enables, bit i covers data[8i+7:8i]
//   read         read request, held until completion
//   write        write request, held until completion (wins over read)
//   data_in      write data
//   data_out     read data; zero when not completing a read
//   hit          request targets this window (combinational)
//   inhibit      stall; the transfer completes when hit=1 and inhibit=0
module arilla_ram_responder #(
  parameter logic [31:0] BaseAddress = 32'h0000_0000,
  parameter int          SizeBytes   = 4096,
  parameter int          WaitStates  = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] address,
  input  logic [3:0]  byte_enable,
  input  logic        read,
  input  logic        write,
  input  logic [31:0] data_in,
  output logic [31:0] data_out,
  output logic        hit,
  output logic        inhibit
);

  localparam int AddrLsb = $clog2(SizeBytes);
  localparam int Depth   = SizeBytes / 4;
  localparam int IdxW    = (Depth > 1) ? $clog2(Depth) : 1;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_e;

  state_e          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [IdxW-1:0] idx_q, idx_d;
  logic [3:0]      be_q, be_d;
  logic [31:0]     wdata_q, wdata_d;
  logic            op_write_q, op_write_d;
  logic [31:0]     rdata_q, rdata_d;

  logic            in_range;
  logic [IdxW-1:0] req_idx;
  logic            mem_we;
  logic [1:0]      unused_addr_lsb;

  // Storage is deliberately left without reset so contents survive rst_n.
  logic [31:0]     mem [Depth];

  assign in_range = (address[31:AddrLsb] == BaseAddress[31:AddrLsb]);
  assign hit      = (read | write) & in_range;

  // Only the completion cycle releases the stall; with no request the
  // line stays low so other responders on the bus are not disturbed.
  assign inhibit  = hit & (state_q != RESP);

  // Gated by hit as well so an aborted read never leaks onto the OR bus.
  assign data_out = (hit && (state_q == RESP) && !op_write_q) ? rdata_q : 32'h0;

  // Byte offset inside a word plays no part in selecting the location.
  assign unused_addr_lsb = address[1:0];

  // A single-word RAM has no index bits to decode.
  if (Depth > 1) begin : g_idx
    assign req_idx = address[AddrLsb-1:2];
  end else begin : g_idx_single
    assign req_idx = '0;
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    be_d       = be_q;
    wdata_d    = wdata_q;
    op_write_d = op_write_q;
    rdata_d    = rdata_q;
    mem_we     = 1'b0;

    case (state_q)
      IDLE: begin
        if (hit) begin
          idx_d      = req_idx;
          be_d       = byte_enable;
          wdata_d    = data_in;
          op_write_d = write;
          cnt_d      = 4'(WaitStates);
          if (WaitStates == 0) begin
            // No wait phase, so the word is fetched on the way into RESP.
            state_d = RESP;
            rdata_d = mem[req_idx];
          end else begin
            state_d = WAIT;
          end
        end
      end

      WAIT: begin
        if (!hit) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            state_d = RESP;
            rdata_d = mem[idx_q];
          end
        end
      end

      RESP: begin
        state_d = IDLE;
        cnt_d   = '0;
        // The write lands on the edge leaving RESP, unless the initiator
        // withdrew the request during the completion cycle.
        mem_we  = hit & op_write_q;
      end

      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      idx_q      <= '0;
      be_q       <= '0;
      wdata_q    <= '0;
      op_write_q <= 1'b0;
      rdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      be_q       <= be_d;
      wdata_q    <= wdata_d;
      op_write_q <= op_write_d;
      rdata_q    <= rdata_d;
    end
  end

  // Lane-masked write port, one enable per byte.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      if (be_q[0]) mem[idx_q][7:0]   <= wdata_q[7:0];
      if (be_q[1]) mem[idx_q][15:8]  <= wdata_q[15:8];
      if (be_q[2]) mem[idx_q][23:16] <= wdata_q[23:16];
      if (be_q[3]) mem[idx_q][31:24] <= wdata_q[31:24];
    end
  end

endmodule

// File: tb/tb_arilla_ram_responder.sv
// tb_arilla_ram_responder
//   Three responders share one window (0x1000, 4 KiB) with WaitStates of
//   1, 0 and 3. A transaction-level model per instance predicts hit,
//   inhibit and data_out every cycle; directed literals pin key values.
module tb_arilla_ram_responder;

  localparam logic [31:0] Base    = 32'h0000_1000;
  localparam int          Size    = 4096;
  localparam int          NumInst = 3;
  localparam int          Words   = Size / 4;
  localparam int          IdxW    = $clog2(Words);
  localparam int          WsTab [NumInst] = '{1, 0, 3};

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  logic [NumInst-1:0][31:0] address;
  logic [NumInst-1:0][31:0] data_in;
  logic [NumInst-1:0][31:0] data_out;
  logic [NumInst-1:0][3:0]  byte_enable;
  logic [NumInst-1:0]       read;
  logic [NumInst-1:0]       write;
  logic [NumInst-1:0]       hit;
  logic [NumInst-1:0]       inhibit;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] merge_bytes(logic [31:0] old_w, logic [31:0] new_w,
                                              logic [3:0] be);
    logic [31:0] r;
    r = old_w;
    for (int b = 0; b < 4; b++) begin
      if (be[b]) r[8*b +: 8] = new_w[8*b +: 8];
    end
    return r;
  endfunction

  for (genvar g = 0; g < NumInst; g++) begin : g_inst
    localparam int Ws = WsTab[g];

    arilla_ram_responder #(
      .BaseAddress(Base),
      .SizeBytes  (Size),
      .WaitStates (Ws)
    ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .address    (address[g]),
      .byte_enable(byte_enable[g]),
      .read       (read[g]),
      .write      (write[g]),
      .data_in    (data_in[g]),
      .data_out   (data_out[g]),
      .hit        (hit[g]),
      .inhibit    (inhibit[g])
    );

    // Model: a transfer is "busy" from the cycle after its first request
    // cycle; age counts cycles since that first cycle, completion at Ws+1.
    bit              busy;
    int              age;
    logic [IdxW-1:0] cap_idx;
    logic [31:0]     cap_data;
    logic [3:0]      cap_be;
    bit              cap_wr;
    logic [31:0]     mem_m [Words];
    bit              known_m [Words];

    logic        exp_hit, exp_done, exp_inh, exp_dvalid;
    logic [31:0] exp_dout;

    always_comb begin
      exp_hit    = (read[g] | write[g]) && ((address[g] / 32'(Size)) == (Base / 32'(Size)));
      exp_done   = exp_hit && busy && (age == Ws + 1);
      exp_inh    = exp_hit && !exp_done;
      exp_dout   = 32'h0;
      exp_dvalid = 1'b1;
      if (exp_done && !cap_wr) begin
        exp_dout   = mem_m[cap_idx];
        exp_dvalid = known_m[cap_idx];
      end
    end

    always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        busy <= 1'b0;
        age  <= 0;
      end else if (!busy) begin
        if (exp_hit) begin
          busy     <= 1'b1;
          age      <= 1;
          cap_idx  <= IdxW'((address[g] % 32'(Size)) >> 2);
          cap_data <= data_in[g];
          cap_be   <= byte_enable[g];
          cap_wr   <= write[g];
        end
      end else if (!exp_hit) begin
        busy <= 1'b0;
      end else if (age == Ws + 1) begin
        busy <= 1'b0;
        if (cap_wr) begin
          mem_m[cap_idx]   <= merge_bytes(known_m[cap_idx] ? mem_m[cap_idx] : 32'h0,
                                          cap_data, cap_be);
          known_m[cap_idx] <= known_m[cap_idx] | (cap_be == 4'hF);
        end
      end else begin
        age <= age + 1;
      end
    end
  end

  task automatic checkOutput(string name, logic [31:0] actual, logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: actual=%h required=%h", name, actual, expected);
    end
  endtask

  task automatic compareOne(int i, logic h, logic inh, logic [31:0] d,
                            logic eh, logic einh, logic [31:0] ed, logic dv);
    checkOutput($sformatf("hit%0d", i), 32'(h), 32'(eh));
    checkOutput($sformatf("inhibit%0d", i), 32'(inh), 32'(einh));
    if (dv) checkOutput($sformatf("data_out%0d", i), d, ed);
  endtask

  task automatic compareAll();
    compareOne(0, hit[0], inhibit[0], data_out[0], g_inst[0].exp_hit, g_inst[0].exp_inh,
               g_inst[0].exp_dout, g_inst[0].exp_dvalid);
    compareOne(1, hit[1], inhibit[1], data_out[1], g_inst[1].exp_hit, g_inst[1].exp_inh,
               g_inst[1].exp_dout, g_inst[1].exp_dvalid);
    compareOne(2, hit[2], inhibit[2], data_out[2], g_inst[2].exp_hit, g_inst[2].exp_inh,
               g_inst[2].exp_dout, g_inst[2].exp_dvalid);
  endtask

  task automatic sample();
    @(negedge clk);
    compareAll();
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(int i, logic rd, logic wr, logic [31:0] addr,
                               logic [31:0] wd, logic [3:0] be);
    read[i]        = rd;
    write[i]       = wr;
    address[i]     = addr;
    data_in[i]     = wd;
    byte_enable[i] = be;
  endtask

  // Holds a request until completion; reports the completion cycle
  // (cycle 0 = first request cycle) and the data seen in that cycle.
  task automatic doXfer(int i, logic rd, logic wr, logic [31:0] addr, logic [31:0] wd,
                        logic [3:0] be, output int cyc, output logic [31:0] rdata);
    bit done;
    done  = 1'b0;
    cyc   = -1;
    rdata = 32'h0;
    applyStimulus(i, rd, wr, addr, wd, be);
    for (int k = 0; k < 40 && !done; k++) begin
      sample();
      if (hit[i] && !inhibit[i]) begin
        done  = 1'b1;
        cyc   = k;
        rdata = data_out[i];
      end
      advance();
    end
    applyStimulus(i, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    checkOutput($sformatf("xfer_done%0d", i), 32'(done), 32'h1);
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int          cyc;
    logic [31:0] rd;

    for (int i = 0; i < NumInst; i++) applyStimulus(i, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);

    // Reset with a request present: inhibit follows hit, data stays 0.
    applyStimulus(0, 1'b1, 1'b0, 32'h0000_1000, 32'h0, 4'h0);
    sample();
    checkOutput("rst_hit", 32'(hit[0]), 32'h1);
    checkOutput("rst_inhibit", 32'(inhibit[0]), 32'h1);
    checkOutput("rst_dout", data_out[0], 32'h0);
    #1;
    applyStimulus(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    advance();
    sample();
    checkOutput("rst_idle_inhibit", 32'(inhibit[0]), 32'h0);
    #1;
    rst_n = 1'b1;
    advance();

    // WaitStates=1: write then read back.
    doXfer(0, 1'b0, 1'b1, 32'h0000_1004, 32'hDEAD_BEEF, 4'hF, cyc, rd);
    checkOutput("ws1_wr_lat", 32'(cyc), 32'd2);
    doXfer(0, 1'b1, 1'b0, 32'h0000_1004, 32'h0, 4'h0, cyc, rd);
    checkOutput("ws1_rd_lat", 32'(cyc), 32'd2);
    checkOutput("ws1_rd_data", rd, 32'hDEAD_BEEF);
    sample();
    checkOutput("ws1_rd_after", data_out[0], 32'h0);
    advance();

    // A write with no lanes enabled leaves the word alone.
    doXfer(0, 1'b0, 1'b1, 32'h0000_1004, 32'hFFFF_FFFF, 4'h0, cyc, rd);
    doXfer(0, 1'b1, 1'b0, 32'h0000_1004, 32'h0, 4'h0, cyc, rd);
    checkOutput("be0_data", rd, 32'hDEAD_BEEF);

    // Byte lanes.
    doXfer(0, 1'b0, 1'b1, 32'h0000_1008, 32'h1122_3344, 4'hF, cyc, rd);
    doXfer(0, 1'b0, 1'b1, 32'h0000_1008, 32'hAABB_CCDD, 4'b0101, cyc, rd);
    doXfer(0, 1'b1, 1'b0, 32'h0000_100A, 32'h0, 4'h0, cyc, rd);
    checkOutput("lanes_data", rd, 32'h11BB_33DD);

    // Out-of-window read is ignored entirely.
    applyStimulus(0, 1'b1, 1'b0, 32'h0000_2000, 32'h0, 4'h0);
    for (int k = 0; k < 3; k++) begin
      sample();
      checkOutput("oow_hit", 32'(hit[0]), 32'h0);
      checkOutput("oow_inhibit", 32'(inhibit[0]), 32'h0);
      checkOutput("oow_dout", data_out[0], 32'h0);
      advance();
    end
    applyStimulus(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);

    // Top word of the window; first an aborted read, then a full one.
    doXfer(0, 1'b0, 1'b1, 32'h0000_1FFC, 32'h0BAD_CAFE, 4'hF, cyc, rd);
    applyStimulus(0, 1'b1, 1'b0, 32'h0000_1FFC, 32'h0, 4'h0);
    sample();
    checkOutput("top_hit", 32'(hit[0]), 32'h1);
    advance();
    applyStimulus(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    sample();
    advance();
    doXfer(0, 1'b1, 1'b0, 32'h0000_1FFC, 32'h0, 4'h0, cyc, rd);
    checkOutput("top_lat", 32'(cyc), 32'd2);
    checkOutput("top_data", rd, 32'h0BAD_CAFE);

    // Read and write together behave as a write.
    doXfer(0, 1'b0, 1'b1, 32'h0000_1014, 32'h0, 4'hF, cyc, rd);
    doXfer(0, 1'b1, 1'b1, 32'h0000_1014, 32'h1234_5678, 4'hF, cyc, rd);
    checkOutput("rw_dout", rd, 32'h0);
    doXfer(0, 1'b1, 1'b0, 32'h0000_1014, 32'h0, 4'h0, cyc, rd);
    checkOutput("rw_data", rd, 32'h1234_5678);

    // WaitStates=0: single-cycle stall, back-to-back reads.
    doXfer(1, 1'b0, 1'b1, 32'h0000_1000, 32'hA5A5_0001, 4'hF, cyc, rd);
    checkOutput("ws0_wr_lat", 32'(cyc), 32'd1);
    doXfer(1, 1'b0, 1'b1, 32'h0000_1004, 32'h5A5A_0002, 4'hF, cyc, rd);
    doXfer(1, 1'b1, 1'b0, 32'h0000_1004, 32'h0, 4'h0, cyc, rd);
    checkOutput("ws0_rd_lat", 32'(cyc), 32'd1);
    applyStimulus(1, 1'b1, 1'b0, 32'h0000_1000, 32'h0, 4'h0);
    sample();
    checkOutput("b2b_c0_inh", 32'(inhibit[1]), 32'h1);
    advance();
    sample();
    checkOutput("b2b_c1_inh", 32'(inhibit[1]), 32'h0);
    checkOutput("b2b_c1_data", data_out[1], 32'hA5A5_0001);
    advance();
    applyStimulus(1, 1'b1, 1'b0, 32'h0000_1004, 32'h0, 4'h0);
    sample();
    checkOutput("b2b_c2_inh", 32'(inhibit[1]), 32'h1);
    checkOutput("b2b_c2_data", data_out[1], 32'h0);
    advance();
    sample();
    checkOutput("b2b_c3_inh", 32'(inhibit[1]), 32'h0);
    checkOutput("b2b_c3_data", data_out[1], 32'h5A5A_0002);
    advance();
    applyStimulus(1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    sample();
    advance();

    // WaitStates=3: abort by dropping the request.
    doXfer(2, 1'b0, 1'b1, 32'h0000_1010, 32'hCAFE_F00D, 4'hF, cyc, rd);
    checkOutput("ws3_wr_lat", 32'(cyc), 32'd4);
    applyStimulus(2, 1'b0, 1'b1, 32'h0000_1010, 32'h0000_0055, 4'hF);
    sample();
    advance();
    applyStimulus(2, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    sample();
    checkOutput("abort_hit", 32'(hit[2]), 32'h0);
    advance();
    sample();
    advance();
    doXfer(2, 1'b1, 1'b0, 32'h0000_1010, 32'h0, 4'h0, cyc, rd);
    checkOutput("abort_data", rd, 32'hCAFE_F00D);

    // Abort by reset pulse in cycle 2.
    applyStimulus(2, 1'b0, 1'b1, 32'h0000_1010, 32'h0000_0055, 4'hF);
    sample();
    advance();
    sample();
    advance();
    rst_n = 1'b0;
    sample();
    checkOutput("rstab_inhibit", 32'(inhibit[2]), 32'h1);
    checkOutput("rstab_dout", data_out[2], 32'h0);
    #1;
    rst_n = 1'b1;
    applyStimulus(2, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    advance();
    doXfer(2, 1'b1, 1'b0, 32'h0000_1010, 32'h0, 4'h0, cyc, rd);
    checkOutput("rstab_lat", 32'(cyc), 32'd4);
    checkOutput("rstab_data", rd, 32'hCAFE_F00D);

    // Address/data changed mid-transfer: captured values win.
    applyStimulus(2, 1'b0, 1'b1, 32'h0000_1018, 32'h0102_0304, 4'hF);
    sample();
    advance();
    applyStimulus(2, 1'b0, 1'b1, 32'h0000_101C, 32'hFFFF_FFFF, 4'hF);
    for (int k = 1; k < 4; k++) begin
      sample();
      advance();
    end
    sample();
    checkOutput("chg_done_inh", 32'(inhibit[2]), 32'h0);
    advance();
    applyStimulus(2, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    doXfer(2, 1'b1, 1'b0, 32'h0000_1018, 32'h0, 4'h0, cyc, rd);
    checkOutput("chg_data", rd, 32'h0102_0304);

    sample();
    advance();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
